// File: rtl/sigma_cpu_if.sv
// Shared word-memory bus between the CPU core and the memory/IOP side.
// Big-endian bit numbering matches the Sigma architecture documentation.
interface sigma_cpu_if;
    logic [15:31] memory_address;
    logic [0:31]  memory_data_in;
    logic [0:31]  memory_data_out;
    logic [0:3]   mem_write_en;

    modport master (
        output memory_address,
        output memory_data_out,
        output mem_write_en,
        input  memory_data_in
    );

    modport slave (
        input  memory_address,
        input  memory_data_out,
        input  mem_write_en,
        output memory_data_in
    );
endinterface

// File: rtl/sigma_cpu.sv
// Compact Sigma-style CPU core: fetch/decode/exec/writeback over a shared
// synchronous word memory, releasing the bus whenever active is low.
module sigma_cpu (
    input  logic          clock,
    input  logic          reset,
    input  logic          active,
    sigma_cpu_if.master   bus,
    output logic [2:0]    iop_func,
    output logic [10:0]   iop_device,
    input  logic [0:1]    iop_cc,
    output logic [6:0]    o,
    output logic [15:31]  p,
    output logic [15:31]  q,
    output logic [0:31]   c,
    output logic          trap,
    output logic          ende
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    localparam logic [6:0] OP_AI   = 7'h20;
    localparam logic [6:0] OP_LI   = 7'h22;
    localparam logic [6:0] OP_WAIT = 7'h2E;
    localparam logic [6:0] OP_AW   = 7'h30;
    localparam logic [6:0] OP_CW   = 7'h31;
    localparam logic [6:0] OP_LW   = 7'h32;
    localparam logic [6:0] OP_STW  = 7'h35;
    localparam logic [6:0] OP_SIO  = 7'h4C;
    localparam logic [6:0] OP_TIO  = 7'h4D;
    localparam logic [6:0] OP_TDV  = 7'h4E;
    localparam logic [6:0] OP_HIO  = 7'h4F;
    localparam logic [6:0] OP_BCR  = 7'h68;
    localparam logic [6:0] OP_BCS  = 7'h69;

    state_t        state;
    logic [0:31]   regs [16];
    logic [1:4]    cc;
    logic [15:31]  ea_q;
    logic [15:31]  addr_q;
    logic [0:31]   wdata_q;
    logic [0:3]    we_q;

    // Decode-side view of the freshly fetched word.
    logic [0:31]   ir;
    logic [6:0]    d_op;
    logic [3:0]    d_r;
    logic [2:0]    d_x;
    logic [15:31]  d_index;
    logic [15:31]  d_ea;
    logic          d_legal;
    logic          d_io;

    // Execute-side operands, all derived from the latched instruction.
    logic [3:0]    r_idx;
    logic [0:31]   rv;
    logic [0:31]   imm;
    logic [0:31]   md;
    logic [0:31]   opnd;
    logic [32:0]   sum33;
    logic [0:31]   sum;
    logic          carry;
    logic          ovf;
    logic          branch_hit;

    function automatic logic [1:0] sign_cc(input logic [0:31] v);
        return {~v[0] & (|v), v[0]};
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ir      = bus.memory_data_in;
        d_op    = ir[1:7];
        d_r     = ir[8:11];
        d_x     = ir[12:14];
        d_index = (d_x != 3'd0) ? regs[{1'b0, d_x}][15:31] : 17'd0;
        d_ea    = ir[15:31] + d_index;
        d_io    = 1'b0;
        d_legal = 1'b0;
        case (d_op)
            OP_LI, OP_AI, OP_LW, OP_AW, OP_CW, OP_STW,
            OP_BCR, OP_BCS, OP_WAIT:          d_legal = 1'b1;
            OP_SIO, OP_TIO, OP_TDV, OP_HIO:   begin d_legal = 1'b1; d_io = 1'b1; end
            default:                          d_legal = 1'b0;
        endcase
        if (ir[0])
            d_legal = 1'b0;
    end

    always_comb begin
        r_idx      = c[8:11];
        rv         = regs[r_idx];
        imm        = {{12{c[12]}}, c[12:31]};
        md         = bus.memory_data_in;
        opnd       = (o == OP_AI) ? imm : md;
        sum33      = {1'b0, rv} + {1'b0, opnd};
        sum        = sum33[31:0];
        carry      = sum33[32];
        ovf        = (rv[0] == opnd[0]) && (sum[0] != rv[0]);
        branch_hit = |(cc & c[8:11]);
    end

    // The bus is only driven while this core owns it.
    assign bus.memory_address  = active ? addr_q  : 'z;
    assign bus.memory_data_out = active ? wdata_q : 'z;
    assign bus.mem_write_en    = active ? we_q    : 'z;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            p          <= '0;
            q          <= '0;
            c          <= '0;
            o          <= '0;
            cc         <= '0;
            trap       <= 1'b0;
            ende       <= 1'b0;
            iop_func   <= '0;
            iop_device <= '0;
            ea_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            // NOTE: the register file is architecturally cleared on reset, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else if (!active) begin
            // Frozen: any in-flight read is discarded and re-issued on resume.
            ende <= 1'b0;
            if (state == S_DECODE)
                state <= S_FETCH;
            else if (state == S_WB)
                state <= S_EXEC;
        end else begin
            ende <= 1'b0;
            case (state)
                S_FETCH: state <= S_DECODE;

                S_DECODE: begin
                    c    <= ir;
                    o    <= d_op;
                    p    <= p + 17'd1;
                    ea_q <= d_ea;
                    if (!d_legal) begin
                        trap  <= 1'b1;
                        q     <= p + 17'd1;
                        state <= S_HALT;
                    end else begin
                        state   <= S_EXEC;
                        addr_q  <= d_ea;
                        wdata_q <= regs[d_r];
                        if (d_op == OP_STW)
                            we_q <= 4'b1111;
                        if (d_io) begin
                            // SIO..HIO are consecutive opcodes mapping to functions 1..4.
                            iop_func   <= {1'b0, d_op[1:0]} + 3'd1;
                            iop_device <= ir[21:31];
                        end
                    end
                end

                S_EXEC: begin
                    state  <= S_FETCH;
                    ende   <= 1'b1;
                    addr_q <= p;
                    case (o)
                        OP_LI: begin
                            regs[r_idx] <= imm;
                            cc[3:4]     <= sign_cc(imm);
                        end
                        OP_AI: begin
                            regs[r_idx] <= sum;
                            cc          <= {carry, ovf, sign_cc(sum)};
                        end
                        OP_BCR, OP_BCS: begin
                            if (branch_hit == (o == OP_BCS)) begin
                                p      <= ea_q;
                                addr_q <= ea_q;
                            end
                        end
                        OP_STW:  we_q  <= 4'b0000;
                        OP_WAIT: state <= S_HALT;
                        default: begin
                            state    <= S_WB;
                            ende     <= 1'b0;
                            addr_q   <= addr_q;
                            iop_func <= '0;
                        end
                    endcase
                end

                S_WB: begin
                    state  <= S_FETCH;
                    ende   <= 1'b1;
                    addr_q <= p;
                    case (o)
                        OP_LW: begin
                            regs[r_idx] <= md;
                            cc[3:4]     <= sign_cc(md);
                        end
                        OP_AW: begin
                            regs[r_idx] <= sum;
                            cc          <= {carry, ovf, sign_cc(sum)};
                        end
                        OP_CW:   cc[3:4] <= {$signed(rv) > $signed(md), $signed(rv) < $signed(md)};
                        default: cc      <= {iop_cc, 2'b00};
                    endcase
                end

                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_sigma_cpu.sv
// Directed bench for sigma_cpu: small programs in a behavioural memory,
// results checked against hand-computed values at fixed cycle counts.
module tb_sigma_cpu;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         active = 1'b1;
    logic [2:0]   iop_func;
    logic [10:0]  iop_device;
    logic [0:1]   iop_cc = 2'b00;
    logic [6:0]   o;
    logic [15:31] p;
    logic [15:31] q;
    logic [0:31]  c;
    logic         trap;
    logic         ende;

    sigma_cpu_if bus ();

    sigma_cpu dut (
        .clock      (clock),
        .reset      (reset),
        .active     (active),
        .bus        (bus.master),
        .iop_func   (iop_func),
        .iop_device (iop_device),
        .iop_cc     (iop_cc),
        .o          (o),
        .p          (p),
        .q          (q),
        .c          (c),
        .trap       (trap),
        .ende       (ende)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:255];
    int          total = 0;
    int          bad = 0;
    int          ende_cnt = 0;
    int          we_cnt = 0;
    int          io_cnt = 0;
    logic [2:0]  last_func = '0;
    logic [10:0] last_dev = '0;

    // Registered-read memory, owned by the CPU only while active is high.
    always @(posedge clock) begin
        if (active) begin
            if (bus.mem_write_en === 4'b1111)
                mem[bus.memory_address[24:31]] <= bus.memory_data_out;
            bus.memory_data_in <= mem[bus.memory_address[24:31]];
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            if (ende === 1'b1) ende_cnt++;
            if (active && bus.mem_write_en === 4'b1111) we_cnt++;
            if (iop_func !== 3'd0) begin
                io_cnt++;
                last_func = iop_func;
                last_dev  = iop_device;
            end
        end
    end

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [3:0] r,
                                        input logic [2:0] x, input logic [16:0] a);
        return {1'b0, op, r, x, a};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [3:0] r,
                                          input logic [19:0] imm);
        return {1'b0, op, r, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start();
        reset  = 1'b0;
        active = 1'b1;
        step(2);
        ende_cnt = 0; we_cnt = 0; io_cnt = 0;
        last_func = '0; last_dev = '0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(2);
        total++; if (p !== 17'd0) begin bad++; $display("FAIL reset_p got %h want 0", p); end
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap got %b want 0", trap); end
        total++; if (ende !== 1'b0) begin bad++; $display("FAIL reset_ende got %b want 0", ende); end
        total++; if (iop_func !== 3'd0) begin bad++; $display("FAIL reset_iop_func got %h want 0", iop_func); end
        total++; if (bus.mem_write_en !== 4'b0000) begin bad++; $display("FAIL reset_we got %b want 0000", bus.mem_write_en); end
        total++; if (bus.memory_address !== 17'd0) begin bad++; $display("FAIL reset_addr got %h want 0", bus.memory_address); end
        total++; if (dut.cc !== 4'b0000) begin bad++; $display("FAIL reset_cc got %b want 0000", dut.cc); end
    endtask

    task automatic test_li_wait();
        clear_mem();
        mem[0] = enc_i(7'h22, 4'd1, 20'd5);
        mem[1] = enc(7'h2E, 4'd0, 3'd0, 17'd0);
        start();
        step(3);
        total++; if (ende !== 1'b1) begin bad++; $display("FAIL li_ende got %b want 1", ende); end
        step(2);
        total++; if (ende !== 1'b0) begin bad++; $display("FAIL li_ende_pulse got %b want 0", ende); end
        step(1);
        total++; if (ende !== 1'b1 || o !== 7'h2E) begin bad++; $display("FAIL wait_end got ende=%b o=%h want 1 2e", ende, o); end
        total++; if (dut.regs[1] !== 32'd5) begin bad++; $display("FAIL li_r1 got %h want 5", dut.regs[1]); end
        total++; if (dut.cc !== 4'b0010) begin bad++; $display("FAIL li_cc got %b want 0010", dut.cc); end
        step(6);
        total++; if (ende_cnt !== 2) begin bad++; $display("FAIL wait_ende_cnt got %0d want 2", ende_cnt); end
        total++; if (p !== 17'd2 || o !== 7'h2E) begin bad++; $display("FAIL wait_halt got p=%h o=%h want 2 2e", p, o); end
    endtask

    task automatic test_add_branch();
        clear_mem();
        mem[0]    = enc_i(7'h22, 4'd2, 20'hFFFFF);
        mem[1]    = enc_i(7'h20, 4'd2, 20'd1);
        mem[2]    = enc(7'h69, 4'd8, 3'd0, 17'h10);
        mem[8'h10] = enc(7'h68, 4'd8, 3'd0, 17'h30);
        mem[8'h11] = enc(7'h2E, 4'd0, 3'd0, 17'd0);
        start();
        step(3);
        total++; if (dut.regs[2] !== 32'hFFFFFFFF || dut.cc !== 4'b0001) begin bad++; $display("FAIL li_neg got r2=%h cc=%b want ffffffff 0001", dut.regs[2], dut.cc); end
        step(3);
        total++; if (dut.regs[2] !== 32'd0 || dut.cc !== 4'b1000) begin bad++; $display("FAIL ai_carry got r2=%h cc=%b want 0 1000", dut.regs[2], dut.cc); end
        step(3);
        total++; if (p !== 17'h10) begin bad++; $display("FAIL bcs_taken got p=%h want 10", p); end
        step(6);
        total++; if (p !== 17'h12 || o !== 7'h2E) begin bad++; $display("FAIL bcr_not_taken got p=%h o=%h want 12 2e", p, o); end
    endtask

    task automatic test_memory_ops();
        clear_mem();
        mem[8'h40] = 32'd7;
        mem[8'h42] = 32'd20;
        mem[0] = enc(7'h32, 4'd3, 3'd0, 17'h40);
        mem[1] = enc(7'h30, 4'd3, 3'd0, 17'h40);
        mem[2] = enc(7'h35, 4'd3, 3'd0, 17'h41);
        mem[3] = enc(7'h31, 4'd3, 3'd0, 17'h42);
        mem[4] = enc(7'h32, 4'd4, 3'd3, 17'h32);
        mem[5] = enc(7'h2E, 4'd0, 3'd0, 17'd0);
        start();
        step(8);
        total++; if (dut.regs[3] !== 32'd14 || dut.cc !== 4'b0010) begin bad++; $display("FAIL lw_aw got r3=%h cc=%b want e 0010", dut.regs[3], dut.cc); end
        step(3);
        total++; if (mem[8'h41] !== 32'd14 || we_cnt !== 1) begin bad++; $display("FAIL stw got m41=%h we=%0d want e 1", mem[8'h41], we_cnt); end
        step(4);
        total++; if (dut.cc !== 4'b0001) begin bad++; $display("FAIL cw_less got cc=%b want 0001", dut.cc); end
        step(7);
        total++; if (dut.regs[4] !== 32'd7 || dut.cc !== 4'b0010) begin bad++; $display("FAIL lw_indexed got r4=%h cc=%b want 7 0010", dut.regs[4], dut.cc); end
        total++; if (o !== 7'h2E || we_cnt !== 1) begin bad++; $display("FAIL mem_end got o=%h we=%0d want 2e 1", o, we_cnt); end
    endtask

    task automatic test_freeze();
        clear_mem();
        mem[0] = enc_i(7'h22, 4'd5, 20'h55);
        mem[1] = enc(7'h35, 4'd5, 3'd0, 17'h20);
        mem[2] = enc_i(7'h22, 4'd6, 20'd3);
        mem[3] = enc(7'h35, 4'd6, 3'd0, 17'h21);
        mem[4] = enc(7'h2E, 4'd0, 3'd0, 17'd0);
        start();
        step(6);
        total++; if (mem[8'h20] !== 32'h55 || p !== 17'd2) begin bad++; $display("FAIL pre_freeze got m20=%h p=%h want 55 2", mem[8'h20], p); end
        active = 1'b0;
        step(10);
        total++; if (p !== 17'd2 || we_cnt !== 1 || mem[8'h21] !== 32'd0) begin bad++; $display("FAIL frozen got p=%h we=%0d m21=%h want 2 1 0", p, we_cnt, mem[8'h21]); end
        active = 1'b1;
        step(1);
        active = 1'b0;
        step(3);
        total++; if (p !== 17'd2) begin bad++; $display("FAIL frozen_decode got p=%h want 2", p); end
        active = 1'b1;
        step(9);
        total++; if (mem[8'h21] !== 32'd3 || dut.regs[6] !== 32'd3 || we_cnt !== 2) begin bad++; $display("FAIL resume got m21=%h r6=%h we=%0d want 3 3 2", mem[8'h21], dut.regs[6], we_cnt); end
        total++; if (o !== 7'h2E || p !== 17'd5) begin bad++; $display("FAIL resume_end got o=%h p=%h want 2e 5", o, p); end
    endtask

    task automatic test_io();
        clear_mem();
        mem[0] = enc(7'h4C, 4'd0, 3'd0, 17'h123);
        mem[1] = enc(7'h4D, 4'd0, 3'd0, 17'h007);
        mem[2] = enc(7'h2E, 4'd0, 3'd0, 17'd0);
        start();
        iop_cc = 2'b10;
        step(4);
        total++; if (io_cnt !== 1 || last_func !== 3'd1 || last_dev !== 11'h123) begin bad++; $display("FAIL sio got n=%0d f=%h d=%h want 1 1 123", io_cnt, last_func, last_dev); end
        total++; if (dut.cc !== 4'b1000) begin bad++; $display("FAIL sio_cc got %b want 1000", dut.cc); end
        iop_cc = 2'b01;
        step(4);
        total++; if (io_cnt !== 2 || last_func !== 3'd2 || last_dev !== 11'h007) begin bad++; $display("FAIL tio got n=%0d f=%h d=%h want 2 2 7", io_cnt, last_func, last_dev); end
        total++; if (dut.cc !== 4'b0100) begin bad++; $display("FAIL tio_cc got %b want 0100", dut.cc); end
        step(5);
        total++; if (iop_func !== 3'd0 || io_cnt !== 2) begin bad++; $display("FAIL io_idle got f=%h n=%0d want 0 2", iop_func, io_cnt); end
    endtask

    task automatic test_trap();
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = enc_i(7'h22, 4'd1, 20'(i + 1));
        mem[5] = 32'h7F000000;
        start();
        step(16);
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL trap_early got %b want 0", trap); end
        step(1);
        total++; if (trap !== 1'b1 || q !== 17'd6 || p !== 17'd6) begin bad++; $display("FAIL trap got t=%b q=%h p=%h want 1 6 6", trap, q, p); end
        step(10);
        total++; if (trap !== 1'b1 || p !== 17'd6 || ende_cnt !== 5 || o !== 7'h7F) begin bad++; $display("FAIL trap_hold got t=%b p=%h e=%0d o=%h want 1 6 5 7f", trap, p, ende_cnt, o); end
        reset = 1'b0;
        #1;
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL trap_clear got %b want 0", trap); end
        clear_mem();
        mem[0] = {1'b1, 7'h32, 4'd1, 3'd0, 17'h40};
        start();
        step(2);
        total++; if (trap !== 1'b1 || q !== 17'd1) begin bad++; $display("FAIL indirect_trap got t=%b q=%h want 1 1", trap, q); end
    endtask

    task automatic test_reset_mid_lw();
        clear_mem();
        mem[8'h40] = 32'h1234;
        mem[0] = enc_i(7'h22, 4'd7, 20'd9);
        mem[1] = enc(7'h32, 4'd8, 3'd0, 17'h40);
        start();
        step(5);
        total++; if (dut.regs[7] !== 32'd9 || p !== 17'd2) begin bad++; $display("FAIL pre_reset got r7=%h p=%h want 9 2", dut.regs[7], p); end
        reset = 1'b0;
        #1;
        total++; if (p !== 17'd0 || dut.regs[7] !== 32'd0 || dut.regs[8] !== 32'd0 || dut.cc !== 4'b0000) begin bad++; $display("FAIL mid_reset got p=%h r7=%h r8=%h cc=%b want 0 0 0 0000", p, dut.regs[7], dut.regs[8], dut.cc); end
        total++; if (trap !== 1'b0 || ende !== 1'b0 || bus.mem_write_en !== 4'b0000 || bus.memory_address !== 17'd0) begin bad++; $display("FAIL mid_reset_bus got t=%b e=%b we=%b a=%h want 0 0 0000 0", trap, ende, bus.mem_write_en, bus.memory_address); end
        step(3);
        total++; if (dut.regs[8] !== 32'd0 || p !== 17'd0) begin bad++; $display("FAIL reset_hold got r8=%h p=%h want 0 0", dut.regs[8], p); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_li_wait();
        test_add_branch();
        test_memory_ops();
        test_freeze();
        test_io();
        test_trap();
        test_reset_mid_lw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
